// File: rtl/pzcorebus_response_arbiter.sv
// N-to-1 round-robin merge of packed corebus response streams.
// A multi-beat response holds the grant until its last beat, so bursts never interleave.
module pzcorebus_response_arbiter #(
   parameter int N              = 2,
   parameter int RESPONSE_WIDTH = 64,
   parameter int PORT_WIDTH     = $clog2(N)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [N-1:0]                i_sresp_valid,
   output logic [N-1:0]                o_mresp_accept,
   input  logic [N*RESPONSE_WIDTH-1:0] i_sresp,
   input  logic [N-1:0]                i_sresp_last,
   output logic                        o_sresp_valid,
   input  logic                        i_mresp_accept,
   output logic [RESPONSE_WIDTH-1:0]   o_sresp,
   output logic                        o_sresp_last,
   output logic [PORT_WIDTH-1:0]       o_grant_port,
   output logic                        o_locked
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [PORT_WIDTH-1:0] lock_port_q, lock_port_d;
   logic [PORT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [PORT_WIDTH-1:0] sel, sel_inc;
   logic                  found;
   int                    idx;
   logic                  hs;

   // Search starts at rr_ptr; with nothing valid, sel parks on rr_ptr.
   always_comb begin
      sel   = rr_ptr_q;
      found = 1'b0;
      idx   = 0;
      if (state_q == LOCKED) begin
         sel = lock_port_q;
      end else begin
         for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && i_sresp_valid[PORT_WIDTH'(idx)]) begin
               sel   = PORT_WIDTH'(idx);
               found = 1'b1;
            end
         end
      end
   end

   // Explicit wrap keeps the pointer below N for non-power-of-2 N.
   assign sel_inc = (int'(sel) == N - 1) ? '0 : sel + PORT_WIDTH'(1);

   assign o_sresp_valid = !i_rst && i_sresp_valid[sel];
   assign o_sresp       = i_sresp[int'(sel)*RESPONSE_WIDTH +: RESPONSE_WIDTH];
   assign o_sresp_last  = i_sresp_last[sel];
   assign o_grant_port  = i_rst ? '0 : sel;
   assign o_locked      = !i_rst && (state_q == LOCKED);
   assign hs            = o_sresp_valid && i_mresp_accept;

   always_comb begin
      o_mresp_accept      = '0;
      o_mresp_accept[sel] = hs;
   end

   always_comb begin
      state_d     = state_q;
      lock_port_d = lock_port_q;
      rr_ptr_d    = rr_ptr_q;
      if (hs) begin
         case (state_q)
            UNLOCKED: begin
               if (!o_sresp_last) begin
                  state_d     = LOCKED;
                  lock_port_d = sel;
               end else begin
                  rr_ptr_d = sel_inc;
               end
            end
            LOCKED: begin
               if (o_sresp_last) begin
                  state_d  = UNLOCKED;
                  rr_ptr_d = sel_inc;
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= UNLOCKED;
         lock_port_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         lock_port_q <= lock_port_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   a_accept_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
      $onehot0(o_mresp_accept));
   a_lock_port_range: assert property (@(posedge i_clk) disable iff (i_rst)
      int'(lock_port_q) < N);
   a_lock_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
      (state_q != LOCKED) || ((o_mresp_accept & ~(N'(1) << lock_port_q)) == '0));

endmodule

// File: tb/tb_pzcorebus_response_arbiter.sv
// Directed scenarios for the response arbiter (N=3); accepted beats are matched
// against a queue of expected {port, data, last} pushed with the stimulus.
module tb_pzcorebus_response_arbiter;

   localparam int N  = 3;
   localparam int W  = 16;
   localparam int PW = 2;

   logic            clk = 1'b0;
   logic            i_rst;
   logic [N-1:0]    i_sresp_valid;
   logic [N-1:0]    o_mresp_accept;
   logic [N*W-1:0]  i_sresp;
   logic [N-1:0]    i_sresp_last;
   logic            o_sresp_valid;
   logic            i_mresp_accept;
   logic [W-1:0]    o_sresp;
   logic            o_sresp_last;
   logic [PW-1:0]   o_grant_port;
   logic            o_locked;

   typedef struct {
      int          port;
      logic [15:0] data;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    in_seq[N];
   int    exp_seq[N];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   pzcorebus_response_arbiter #(.N(N), .RESPONSE_WIDTH(W), .PORT_WIDTH(PW)) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_sresp_valid  (i_sresp_valid),
      .o_mresp_accept (o_mresp_accept),
      .i_sresp        (i_sresp),
      .i_sresp_last   (i_sresp_last),
      .o_sresp_valid  (o_sresp_valid),
      .i_mresp_accept (i_mresp_accept),
      .o_sresp        (o_sresp),
      .o_sresp_last   (o_sresp_last),
      .o_grant_port   (o_grant_port),
      .o_locked       (o_locked)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic exp_beat(input int p, input logic l);
      beat_t e;
      e.port = p;
      e.data = {4'(p), 12'(exp_seq[p])};
      e.last = l;
      sb.push_back(e);
      exp_seq[p]++;
   endtask

   // One cycle: drive after the edge, sample at the falling edge, retire any handshake.
   task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic a);
      beat_t e;
      @(posedge clk); #1;
      i_sresp_valid  = v;
      i_sresp_last   = l;
      i_mresp_accept = a;
      for (int k = 0; k < N; k++) i_sresp[k*W +: W] = {4'(k), 12'(in_seq[k])};
      @(negedge clk);
      if (o_sresp_valid && i_mresp_accept) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_hs", 32'(o_grant_port), 32'hffff);
         end else begin
            e = sb.pop_front();
            chk("hs_port", 32'(o_grant_port), 32'(e.port));
            chk("hs_data", 32'(o_sresp), 32'(e.data));
            chk("hs_last", 32'(o_sresp_last), 32'(e.last));
            chk("hs_accept", 32'(o_mresp_accept), 32'(3'(1) << e.port));
            in_seq[e.port]++;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         in_seq[k]  = 1;
         exp_seq[k] = 1;
      end
      i_rst          = 1'b1;
      i_sresp_valid  = '1;
      i_sresp_last   = '1;
      i_mresp_accept = 1'b1;
      for (int k = 0; k < N; k++) i_sresp[k*W +: W] = {4'(k), 12'(in_seq[k])};

      // reset with every input valid
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(o_sresp_valid), 0);
      chk("rst_accept", 32'(o_mresp_accept), 0);
      chk("rst_locked", 32'(o_locked), 0);
      chk("rst_grant", 32'(o_grant_port), 0);
      i_mresp_accept = 1'b0;
      @(posedge clk); #1;
      i_rst = 1'b0;

      // round robin, single-beat
      for (int c = 0; c < 6; c++) begin
         exp_beat(c % N, 1'b1);
         drive(3'b111, 3'b111, 1'b1);
      end
      chk("rr_drain", 32'(sb.size()), 0);

      // 4-beat burst on port 0 while port 1 waits
      for (int b = 0; b < 4; b++) begin
         exp_beat(0, b == 3);
         drive(3'b011, (b == 3) ? 3'b011 : 3'b010, 1'b1);
         chk("burst_locked", 32'(o_locked), (b == 0) ? 0 : 1);
      end
      exp_beat(1, 1'b1);
      drive(3'b011, 3'b011, 1'b1);
      chk("burst_next_locked", 32'(o_locked), 0);
      chk("burst_drain", 32'(sb.size()), 0);

      // backpressure mid-burst on port 0 (pointer now 2)
      exp_beat(0, 1'b0);
      drive(3'b011, 3'b010, 1'b1);
      exp_beat(0, 1'b0);
      drive(3'b011, 3'b010, 1'b1);
      for (int s = 0; s < 5; s++) begin
         drive(3'b011, 3'b010, 1'b0);
         chk("stall_data", 32'(o_sresp), 32'({4'h0, 12'(exp_seq[0])}));
         chk("stall_last", 32'(o_sresp_last), 0);
         chk("stall_accept", 32'(o_mresp_accept), 0);
         chk("stall_locked", 32'(o_locked), 1);
      end
      exp_beat(0, 1'b1);
      drive(3'b011, 3'b011, 1'b1);
      chk("bp_drain", 32'(sb.size()), 0);

      // bubble in a 3-beat burst on port 1 while port 0 stays valid
      exp_beat(1, 1'b0);
      drive(3'b011, 3'b001, 1'b1);
      for (int s = 0; s < 2; s++) begin
         drive(3'b001, 3'b001, 1'b1);
         chk("bubble_valid", 32'(o_sresp_valid), 0);
         chk("bubble_grant", 32'(o_grant_port), 1);
         chk("bubble_accept", 32'(o_mresp_accept), 0);
      end
      exp_beat(1, 1'b0);
      drive(3'b011, 3'b001, 1'b1);
      exp_beat(1, 1'b1);
      drive(3'b011, 3'b011, 1'b1);
      chk("bubble_drain", 32'(sb.size()), 0);

      // wrap from port 2, then reset while locked on port 1
      exp_beat(2, 1'b1);
      drive(3'b100, 3'b100, 1'b1);
      exp_beat(0, 1'b1);
      drive(3'b111, 3'b111, 1'b1);
      exp_beat(1, 1'b0);
      drive(3'b010, 3'b000, 1'b1);
      exp_beat(1, 1'b0);
      drive(3'b010, 3'b000, 1'b1);
      chk("pre_rst_locked", 32'(o_locked), 1);
      #1;
      i_rst = 1'b1;
      #1;
      chk("midrst_locked", 32'(o_locked), 0);
      chk("midrst_valid", 32'(o_sresp_valid), 0);
      chk("midrst_accept", 32'(o_mresp_accept), 0);
      chk("midrst_grant", 32'(o_grant_port), 0);
      @(posedge clk); #1;
      i_mresp_accept = 1'b0;
      i_rst = 1'b0;
      exp_beat(0, 1'b1);
      drive(3'b111, 3'b111, 1'b1);
      chk("final_drain", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
